// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, Avalon-style word reads, instruction latch and
// branch-delay-slot redirect handling. Optional stall counter: IFETCH_STALL_COUNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
`ifdef IFETCH_STALL_COUNT_EN
    output logic [31:0] stall_count,
`endif
    output logic        active
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic        mem_read_q;
    logic        instr_valid_q;
    logic        active_q;
    logic        pending_q;
    logic [31:0] pending_target_q;
    logic        handshake_s;
    logic [31:0] next_pc_d;

    // Consume handshake and the PC that follows the consumed instruction.
    always_comb begin
        handshake_s = 1'b0;
        next_pc_d   = pc_q + 32'd4;
        if (state_q == S_HOLD) begin
            handshake_s = instr_valid_q & instr_ready;
        end else begin
            handshake_s = 1'b0;
        end
        if (pending_q) begin
            next_pc_d = pending_target_q;
        end else begin
            next_pc_d = pc_q + 32'd4;
        end
    end

    // Fetch FSM with registered bus and decode-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_FETCH;
            pc_q             <= RESET_VECTOR;
            instr_q          <= 32'd0;
            pc_out_q         <= 32'd0;
            mem_read_q       <= 1'b0;
            instr_valid_q    <= 1'b0;
            active_q         <= 1'b1;
            pending_q        <= 1'b0;
            pending_target_q <= 32'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_read_q && !mem_waitrequest) begin
                        instr_q       <= mem_readdata;
                        pc_out_q      <= pc_q;
                        mem_read_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end else begin
                        mem_read_q    <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (handshake_s) begin
                        instr_valid_q <= 1'b0;
                        // A redirect arriving in a delay slot loses to the pending target.
                        if (pending_q) begin
                            pending_q <= 1'b0;
                        end else if (redirect) begin
                            pending_q        <= 1'b1;
                            pending_target_q <= redirect_target;
                        end
                        if (next_pc_d == HALT_ADDR) begin
                            active_q   <= 1'b0;
                            mem_read_q <= 1'b0;
                            state_q    <= S_HALTED;
                        end else begin
                            pc_q       <= next_pc_d;
                            mem_read_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_HALTED: begin
                    mem_read_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    active_q      <= 1'b0;
                end
                default: begin
                    mem_read_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    active_q      <= 1'b0;
                    state_q       <= S_HALTED;
                end
            endcase
        end
    end

`ifdef IFETCH_STALL_COUNT_EN
    logic [31:0] stall_count_q;

    // Saturating count of request cycles stalled by waitrequest.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else if (state_q != S_HALTED && mem_read_q && mem_waitrequest
                     && stall_count_q != 32'hFFFFFFFF) begin
            stall_count_q <= stall_count_q + 32'd1;
        end else begin
            stall_count_q <= stall_count_q;
        end
    end

    assign stall_count = stall_count_q;
`endif

    assign mem_address = {pc_q[31:2], 2'b00};
    assign mem_read    = mem_read_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc_out      = pc_out_q;
    assign instr_valid = instr_valid_q;
    assign active      = active_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// traffic checked against a transaction-level PC/delay-slot model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        active;
`ifdef IFETCH_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    int passed = 0;
    int total  = 0;

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .instr           (instr),
        .opcode          (opcode),
        .funct           (funct),
        .pc_out          (pc_out),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
`ifdef IFETCH_STALL_COUNT_EN
        .stall_count     (stall_count),
`endif
        .active          (active)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RV) return 32'h00851020;
        return (a ^ 32'hA5A53C3C) + 32'h01010101;
    endfunction

    assign mem_readdata = mem_word(mem_address);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_addr", mem_address, RV);
    endtask

    // Wait (bounded) for a valid instruction, check it, then consume it.
    task automatic take(input logic [31:0] exp_pc, input logic rd, input logic [31:0] tgt);
        int n;
        logic [31:0] e;
        n = 0;
        while (!instr_valid && n < 40) begin
            step();
            n++;
        end
        e = mem_word(exp_pc);
        check("take_valid", {31'd0, instr_valid}, 32'd1);
        check("take_pc_out", pc_out, exp_pc);
        check("take_instr", instr, e);
        check("take_opcode", {26'd0, opcode}, {26'd0, e[31:26]});
        check("take_funct", {26'd0, funct}, {26'd0, e[5:0]});
        instr_ready = 1'b1;
        redirect = rd;
        redirect_target = tgt;
        step();
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_target = $urandom;
    endtask

    task automatic check_halted(input string tag);
        check({tag, "_active"}, {31'd0, active}, 32'd0);
        check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    // Randomized traffic against a transaction-level model of the PC sequence.
    task automatic run_random(input int n_tx);
        logic [31:0] m_pc, m_tgt, tgt, nxt, r;
        logic m_pend, rd;
        int n;
        m_pc = RV;
        m_pend = 1'b0;
        m_tgt = 32'd0;
        for (int t = 0; t < n_tx; t++) begin
            n = 0;
            while (!instr_valid && n < 40) begin
                check("rnd_addr", mem_address, m_pc);
                mem_waitrequest = ($urandom_range(0, 2) == 0);
                step();
                n++;
            end
            mem_waitrequest = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            rd = ($urandom_range(0, 3) == 0);
            r = $urandom;
            tgt = ($urandom_range(0, 7) == 0) ? 32'd0 : {r[31:2], 2'b00};
            take(m_pc, rd, tgt);
            if (m_pend) begin
                nxt = m_tgt;
                m_pend = 1'b0;
            end else begin
                nxt = m_pc + 32'd4;
                if (rd) begin
                    m_pend = 1'b1;
                    m_tgt = tgt;
                end
            end
            if (nxt == 32'd0) begin
                check_halted("rnd_halt");
                return;
            end
            m_pc = nxt;
            check("rnd_next", mem_address, m_pc);
            check("rnd_next_rd", {31'd0, mem_read}, 32'd1);
        end
    endtask

    initial begin
        logic [31:0] held_instr, held_pc;
        int n;
        reset = 1'b1;
        mem_waitrequest = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'd0;

        // Basic fetch with minimum latency
        do_reset();
        step();
        check("t1_req", {31'd0, mem_read}, 32'd1);
        check("t1_addr", mem_address, RV);
        check("t1_notvalid", {31'd0, instr_valid}, 32'd0);
        step();
        check("t1_valid", {31'd0, instr_valid}, 32'd1);
        check("t1_opcode", {26'd0, opcode}, 32'h00);
        check("t1_funct", {26'd0, funct}, 32'h20);
        check("t1_pc_out", pc_out, RV);
        check("t1_idle", {31'd0, mem_read}, 32'd0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("t1_next_addr", mem_address, RV + 32'd4);
        check("t1_next_req", {31'd0, mem_read}, 32'd1);

        // Waitrequest stall on the first fetch
        mem_waitrequest = 1'b1;
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_req", {31'd0, mem_read}, 32'd1);
            check("t2_addr", mem_address, RV);
            check("t2_notvalid", {31'd0, instr_valid}, 32'd0);
        end
`ifdef IFETCH_STALL_COUNT_EN
        check("t2_stalls", stall_count, 32'd3);
`endif
        mem_waitrequest = 1'b0;
        step();
        check("t2_valid", {31'd0, instr_valid}, 32'd1);
        check("t2_pc_out", pc_out, RV);

        // Branch with delay slot, then hold, then jr to 0
        do_reset();
        step();
        take(RV, 1'b0, 32'd0);
        take(RV + 32'h4, 1'b0, 32'd0);
        take(RV + 32'h8, 1'b0, 32'd0);
        take(RV + 32'hC, 1'b0, 32'd0);
        take(RV + 32'h10, 1'b1, RV + 32'h100);
        check("t3_delay_addr", mem_address, RV + 32'h14);
        take(RV + 32'h14, 1'b0, 32'd0);
        check("t3_target_addr", mem_address, RV + 32'h100);
        take(RV + 32'h100, 1'b0, 32'd0);
        n = 0;
        while (!instr_valid && n < 40) begin
            step();
            n++;
        end
        held_instr = instr;
        held_pc = pc_out;
        check("t4_pc", held_pc, RV + 32'h104);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_instr", instr, held_instr);
            check("t4_pc_out", pc_out, held_pc);
            check("t4_valid", {31'd0, instr_valid}, 32'd1);
            check("t4_idle", {31'd0, mem_read}, 32'd0);
        end
        take(RV + 32'h104, 1'b1, 32'd0);
        check("t5_delay_addr", mem_address, RV + 32'h108);
        take(RV + 32'h108, 1'b1, RV + 32'h200);
        check_halted("t5_halt");
        repeat (3) step();
        check_halted("t5_stay");
        do_reset();
        step();
        check("t5_restart_req", {31'd0, mem_read}, 32'd1);
        check("t5_restart_addr", mem_address, RV);

        // Branch in a delay slot: first target wins; sequential wrap halts
        take(RV, 1'b1, 32'hFFFFFFF8);
        take(RV + 32'h4, 1'b1, RV + 32'h80);
        check("bds_addr", mem_address, 32'hFFFFFFF8);
        take(32'hFFFFFFF8, 1'b0, 32'd0);
        check("wrap_addr", mem_address, 32'hFFFFFFFC);
        take(32'hFFFFFFFC, 1'b0, 32'd0);
        check_halted("wrap_halt");

        // Reset while a read is stalled
        do_reset();
        mem_waitrequest = 1'b1;
        step();
        step();
        check("t6_stalled", {31'd0, mem_read}, 32'd1);
        reset = 1'b1;
        step();
        check("t6_abandon", {31'd0, mem_read}, 32'd0);
        check("t6_pc", mem_address, RV);
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        step();
        check("t6_restart", {31'd0, mem_read}, 32'd1);
        check("t6_restart_addr", mem_address, RV);
        step();
        check("t6_valid", {31'd0, instr_valid}, 32'd1);
        check("t6_pc_out", pc_out, RV);

        // Randomized traffic
        for (int k = 0; k < 4; k++) begin
            do_reset();
            step();
            run_random(60);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
